// File: rtl/an_pkg.sv
// Shared constants, state type and phase-sequencing helper for the auto-negotiation sender.
package an_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D16_2 = 8'h50;

    // SGMII config word field positions
    localparam int unsigned CFG_LINK_BIT   = 15;
    localparam int unsigned CFG_ACK_BIT    = 14;
    localparam int unsigned CFG_DUPLEX_BIT = 12;
    localparam int unsigned CFG_SPEED_HI   = 11;
    localparam int unsigned CFG_SPEED_LO   = 10;
    localparam int unsigned CFG_SGMII_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        CFG   = 2'd2,
        ACK   = 2'd3
    } an_state_t;

    // First non-empty phase after 'from'; IDLE when every remaining phase has a zero count
    function automatic an_state_t an_next_phase(input an_state_t from, input logic brk_nz,
                                                input logic cfg_nz, input logic ack_nz);
        an_state_t nxt;
        nxt = IDLE;
        if (from == IDLE && brk_nz)
            nxt = BREAK;
        else if ((from == IDLE || from == BREAK) && cfg_nz)
            nxt = CFG;
        else if (from != ACK && ack_nz)
            nxt = ACK;
        return nxt;
    endfunction

endpackage

// File: rtl/an_ord_gen_mux.sv
// Code-group selection for one ordered-set phase: /I2/ in IDLE, /C1/ or /C2/ otherwise.
module an_ord_mux
    import an_pkg::*;
#(
    parameter int unsigned ACK_BIT = 14
) (
    input  logic [1:0]  phase,
    input  an_state_t   state,
    input  logic        tog_c2,
    input  logic [15:0] cfg,
    output logic [7:0]  data_c,
    output logic        is_k_c
);

    localparam logic [15:0] ACK_MASK = 16'(1) << ACK_BIT;

    logic [15:0] word;

    // Config word per state, then byte pick by phase
    always_comb begin
        word   = 16'h0000;
        data_c = K28_5;
        is_k_c = 1'b1;
        case (state)
            CFG:     word = cfg & ~ACK_MASK;
            ACK:     word = cfg | ACK_MASK;
            default: word = 16'h0000;
        endcase
        if (state == IDLE) begin
            if (phase[0]) begin
                data_c = D16_2;
                is_k_c = 1'b0;
            end
        end else begin
            case (phase)
                2'd1: begin
                    data_c = tog_c2 ? D2_2 : D21_5;
                    is_k_c = 1'b0;
                end
                2'd2: begin
                    data_c = word[7:0];
                    is_k_c = 1'b0;
                end
                2'd3: begin
                    data_c = word[15:8];
                    is_k_c = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/an_ord_gen.sv
// Auto-negotiation ordered-set generator: IDLE -> BREAK -> CFG -> ACK -> IDLE, switching only at set boundaries.
module an_ord_gen
    import an_pkg::*;
#(
    parameter int unsigned BRK_W   = 24,
    parameter int unsigned SET_W   = 8,
    parameter int unsigned ACK_BIT = 14
) (
    input  logic             sgmii_clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      an_config,
    input  logic [BRK_W-1:0] breaklink_cycles,
    input  logic [SET_W-1:0] cfg_sets,
    input  logic [SET_W-1:0] ack_sets,
    output logic [7:0]       tx_data,
    output logic             tx_is_k,
    output logic             busy,
    output logic             done
);

    logic [1:0]       phase_q, phase_d;
    an_state_t        state_q, state_d;
    logic             tog_q, tog_d;
    logic [15:0]      cfg_q, cfg_d, run_cfg_q, run_cfg_d;
    logic [BRK_W-1:0] blk_q, blk_d, brk_cnt_q, brk_cnt_d, brk_inc;
    logic [SET_W-1:0] cset_q, cset_d, aset_q, aset_d, set_cnt_q, set_cnt_d;
    logic             go_pend_q, go_pend_d, abt_pend_q, abt_pend_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_is_k_q, tx_is_k_d;
    logic             start_go, boundary, entering;

    // Next-state, counters and request bookkeeping; all state moves happen as phase wraps to 0
    always_comb begin
        start_go   = start & ~abort;
        boundary   = (phase_q == 2'd3);
        phase_d    = phase_q + 2'd1;
        cfg_d      = start_go ? an_config        : cfg_q;
        blk_d      = start_go ? breaklink_cycles : blk_q;
        cset_d     = start_go ? cfg_sets         : cset_q;
        aset_d     = start_go ? ack_sets         : aset_q;
        run_cfg_d  = run_cfg_q;
        go_pend_d  = go_pend_q | start_go;
        abt_pend_d = abt_pend_q & ~start_go;
        state_d    = state_q;
        tog_d      = tog_q;
        brk_cnt_d  = brk_cnt_q;
        set_cnt_d  = set_cnt_q;
        busy_d     = busy_q | start_go;
        done_d     = 1'b0;
        entering   = 1'b0;
        brk_inc    = (&brk_cnt_q) ? brk_cnt_q : brk_cnt_q + BRK_W'(1);

        if (abort && busy_q) begin
            abt_pend_d = 1'b1;
            go_pend_d  = 1'b0;
        end

        if (state_q == BREAK)
            brk_cnt_d = brk_inc;

        if (boundary) begin
            if (abt_pend_d) begin
                state_d = IDLE;
            end else if (go_pend_d) begin
                state_d   = an_next_phase(IDLE, blk_d != '0, cset_d != '0, aset_d != '0);
                run_cfg_d = cfg_d;
            end else begin
                case (state_q)
                    BREAK: if (brk_inc >= blk_q)
                        state_d = an_next_phase(BREAK, 1'b0, cset_q != '0, aset_q != '0);
                    CFG: if (set_cnt_q + SET_W'(1) == cset_q)
                        state_d = an_next_phase(CFG, 1'b0, 1'b0, aset_q != '0);
                    ACK: if (set_cnt_q + SET_W'(1) == aset_q)
                        state_d = IDLE;
                    default: ;
                endcase
            end

            done_d    = ~abt_pend_d & (state_d == IDLE) & (go_pend_d | (state_q != IDLE));
            entering  = go_pend_d | (state_d != state_q);
            brk_cnt_d = (!entering && state_q == BREAK) ? brk_inc : '0;
            set_cnt_d = (!entering && (state_q == CFG || state_q == ACK)) ?
                        set_cnt_q + SET_W'(1) : '0;
            tog_d     = (state_d == IDLE || go_pend_d) ? 1'b0 : ~tog_q;
            if (abt_pend_d || done_d)
                busy_d = 1'b0;
            go_pend_d  = 1'b0;
            abt_pend_d = 1'b0;
        end
    end

    an_ord_mux #(
        .ACK_BIT (ACK_BIT)
    ) u_mux (
        .phase  (phase_d),
        .state  (state_d),
        .tog_c2 (tog_d),
        .cfg    (run_cfg_d),
        .data_c (tx_data_d),
        .is_k_c (tx_is_k_d)
    );

    // State and output registers
    always_ff @(posedge sgmii_clk_in or posedge reset) begin
        if (reset) begin
            phase_q    <= 2'd0;
            state_q    <= IDLE;
            tog_q      <= 1'b0;
            cfg_q      <= '0;
            run_cfg_q  <= '0;
            blk_q      <= '0;
            cset_q     <= '0;
            aset_q     <= '0;
            brk_cnt_q  <= '0;
            set_cnt_q  <= '0;
            go_pend_q  <= 1'b0;
            abt_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= K28_5;
            tx_is_k_q  <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            state_q    <= state_d;
            tog_q      <= tog_d;
            cfg_q      <= cfg_d;
            run_cfg_q  <= run_cfg_d;
            blk_q      <= blk_d;
            cset_q     <= cset_d;
            aset_q     <= aset_d;
            brk_cnt_q  <= brk_cnt_d;
            set_cnt_q  <= set_cnt_d;
            go_pend_q  <= go_pend_d;
            abt_pend_q <= abt_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_is_k_q  <= tx_is_k_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_is_k = tx_is_k_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_an_ord_gen.sv
// Randomised bench for an_ord_gen against a queue-of-ordered-sets reference model.
module tb_an_ord_gen;

    localparam int unsigned BRK_W = 24;
    localparam int unsigned SET_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [15:0]      an_config;
    logic [BRK_W-1:0] blc;
    logic [SET_W-1:0] csets, asets;
    logic [7:0]       tx_data;
    logic             tx_is_k, busy, done;

    always #4 clk = ~clk;

    an_ord_gen #(.BRK_W(BRK_W), .SET_W(SET_W), .ACK_BIT(14)) dut (
        .sgmii_clk_in     (clk),
        .reset            (rst),
        .start            (start),
        .abort            (abort),
        .an_config        (an_config),
        .breaklink_cycles (blc),
        .cfg_sets         (csets),
        .ack_sets         (asets),
        .tx_data          (tx_data),
        .tx_is_k          (tx_is_k),
        .busy             (busy),
        .done             (done)
    );

    typedef struct packed {
        logic        c2;
        logic [15:0] word;
    } oset_t;

    oset_t       run_q[$];
    oset_t       pend_l[$];
    oset_t       m_cur;
    int          m_phase;
    bit          m_run, m_pend, m_abt, m_idle;
    logic [7:0]  e_data;
    logic        e_k, e_busy, e_done;
    int          n_checks, n_errors, done_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The whole negotiation as a list of ordered sets, C1/C2 alternating from C1
    function automatic void build_list();
        bit c2;
        int nb;
        c2 = 1'b0;
        pend_l.delete();
        nb = (int'(blc) + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            pend_l.push_back('{c2, 16'h0000});
            c2 = ~c2;
        end
        for (int i = 0; i < int'(csets); i++) begin
            pend_l.push_back('{c2, an_config & 16'hBFFF});
            c2 = ~c2;
        end
        for (int i = 0; i < int'(asets); i++) begin
            pend_l.push_back('{c2, an_config | 16'h4000});
            c2 = ~c2;
        end
    endfunction

    function automatic void model_reset();
        run_q.delete();
        pend_l.delete();
        m_phase = 0; m_run = 0; m_pend = 0; m_abt = 0; m_idle = 1;
        e_data = 8'hBC; e_k = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs presented this cycle
    function automatic void model_step();
        if (start && !abort) begin
            build_list();
            m_pend = 1; m_abt = 0;
        end else if (abort && e_busy) begin
            m_abt = 1; m_pend = 0;
        end
        m_phase = (m_phase + 1) % 4;
        e_done = 1'b0;
        if (m_phase == 0) begin
            if (m_abt) begin
                run_q.delete(); m_run = 0; m_abt = 0;
            end else if (m_pend) begin
                run_q = pend_l; m_run = 1; m_pend = 0;
            end
            m_idle = 1;
            if (m_run) begin
                if (run_q.size() > 0) begin
                    m_cur = run_q.pop_front();
                    m_idle = 0;
                end else begin
                    m_run = 0;
                    e_done = 1'b1;
                end
            end
        end
        e_busy = m_run | m_pend | m_abt;
        if (m_idle) begin
            e_data = (m_phase % 2 == 0) ? 8'hBC : 8'h50;
            e_k    = (m_phase % 2 == 0);
        end else begin
            e_k = (m_phase == 0);
            case (m_phase)
                0: e_data = 8'hBC;
                1: e_data = m_cur.c2 ? 8'h42 : 8'hB5;
                2: e_data = m_cur.word[7:0];
                default: e_data = m_cur.word[15:8];
            endcase
        end
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("tx_is_k", 32'(tx_is_k), 32'(e_k));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        if (done === 1'b1) done_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int p);
        while (m_phase != p) tick();
    endtask

    task automatic do_start(input logic [15:0] c, input int b, input int cs, input int as_n);
        an_config = c;
        blc       = BRK_W'(b);
        csets     = SET_W'(cs);
        asets     = SET_W'(as_n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        an_config = 16'($urandom);
        blc       = BRK_W'($urandom_range(0, 60));
        csets     = SET_W'($urandom_range(0, 9));
        asets     = SET_W'($urandom_range(0, 9));
    endtask

    initial begin
        n_checks = 0; n_errors = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        an_config = '0; blc = '0; csets = '0; asets = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(tx_data), 32'h0BC);
        chk("rst_k", 32'(tx_is_k), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Idles after reset
        ticks(16);

        // Nominal negotiation
        wait_phase(0);
        done_seen = 0;
        do_start(16'h0001, 20, 3, 2);
        ticks(60);
        chk("nominal_done_cnt", 32'(done_seen), 32'd1);

        // All counts zero
        done_seen = 0;
        do_start(16'h1234, 0, 0, 0);
        ticks(8);
        chk("zero_done_cnt", 32'(done_seen), 32'd1);

        // Start at each phase
        for (int p = 1; p < 4; p++) begin
            wait_phase(p);
            do_start(16'($urandom), 4, 1, 1);
            ticks(20);
        end

        // Abort mid CFG set
        done_seen = 0;
        wait_phase(0);
        do_start(16'h1234, 4, 6, 2);
        ticks(12);
        wait_phase(1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ticks(24);
        chk("abort_done_cnt", 32'(done_seen), 32'd0);

        // Restart during ACK with a new config
        done_seen = 0;
        wait_phase(0);
        do_start(16'h0001, 8, 2, 3);
        ticks(22);
        wait_phase(2);
        do_start(16'h4001, 8, 2, 3);
        ticks(60);
        chk("restart_done_cnt", 32'(done_seen), 32'd1);

        // Start together with abort during a run
        do_start(16'h00A5, 8, 3, 3);
        ticks(9);
        an_config = 16'hFFFF;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        ticks(16);

        // Reset in the middle of a set
        do_start(16'h5A5A, 8, 4, 4);
        ticks(13);
        #1 rst = 1'b1;
        #1;
        chk("midrst_data", 32'(tx_data), 32'h0BC);
        chk("midrst_k", 32'(tx_is_k), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ticks(8);

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if ($urandom_range(0, 7) == 0) abort = 1'b1;
                do_start(16'($urandom), $urandom_range(0, 24),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                abort = 1'b0;
            end else if (r < 8) begin
                abort = 1'b1;
                ticks($urandom_range(1, 3));
                abort = 1'b0;
            end
            ticks($urandom_range(0, 40));
        end
        ticks(120);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
